// File: rtl/dist_ram_pkg.sv
// Shared constants, pointer type and full-compare helper for dist_ram_fifo.
// Optional threshold flags are enabled with the DIST_RAM_FIFO_THRESH_EN macro.
package dist_ram_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_AW    = 8;
    localparam int MAX_AW    = 10;

    // Wide enough for any legal AW; narrower pointers are zero-extended into it.
    typedef logic [MAX_AW:0] ptr_t;

    // Full when the address bits match and the wrap bits (bit aw) differ.
    function automatic logic ptr_full(input ptr_t w, input ptr_t r, input int unsigned aw);
        ptr_t mask;
        mask = ptr_t'((1 << aw) - 1);
        return ((w & mask) == (r & mask)) && (w[aw] != r[aw]);
    endfunction

endpackage

// File: rtl/ram_dist_sdp.sv
// Simple dual-port distributed RAM: synchronous write port, asynchronous read port.
module ram_dist_sdp
    import dist_ram_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int AW    = DEF_AW
) (
    input  logic             CLK,
    input  logic             WE,
    input  logic [AW-1:0]    WA,
    input  logic [WIDTH-1:0] D,
    input  logic [AW-1:0]    RA,
    output logic [WIDTH-1:0] O
);

    logic [WIDTH-1:0] r_mem [0:(2**AW)-1];

    always_ff @(posedge CLK) begin
        if (WE) begin
            r_mem[WA] <= D;
        end
    end

    assign O = r_mem[RA];

endmodule

// File: rtl/dist_ram_fifo.sv
// First-word-fall-through synchronous FIFO on distributed RAM with sticky OVF/UNF.
// Define DIST_RAM_FIFO_THRESH_EN to add registered AFULL/AEMPTY threshold flags.
module dist_ram_fifo
    import dist_ram_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int AW    = DEF_AW
`ifdef DIST_RAM_FIFO_THRESH_EN
    ,
    parameter int AF_LVL = (2**AW) - 4,
    parameter int AE_LVL = 4
`endif
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] D,
    input  logic             WE,
    output logic             FULL,
    output logic [WIDTH-1:0] O,
    input  logic             RE,
    output logic             EMPTY,
    output logic [AW:0]      COUNT,
    output logic             OVF,
    output logic             UNF
`ifdef DIST_RAM_FIFO_THRESH_EN
    ,
    output logic             AFULL,
    output logic             AEMPTY
`endif
);

    logic [AW:0] r_wptr;
    logic [AW:0] r_rptr;
    logic [AW:0] r_count;
    logic        r_full;
    logic        r_empty;
    logic        r_ovf;
    logic        r_unf;

    logic        w_wr_ok;
    logic        w_rd_ok;
    logic [AW:0] w_wptr_nxt;
    logic [AW:0] w_rptr_nxt;
    logic [AW:0] w_count_nxt;

    // Accepts use only registered flags, so WE/RE never reach FULL/EMPTY/COUNT combinationally.
    assign w_wr_ok    = WE & ~r_full;
    assign w_rd_ok    = RE & ~r_empty;
    assign w_wptr_nxt = r_wptr + {{AW{1'b0}}, w_wr_ok};
    assign w_rptr_nxt = r_rptr + {{AW{1'b0}}, w_rd_ok};

    always_comb begin
        w_count_nxt = r_count;
        if (w_wr_ok && !w_rd_ok) begin
            w_count_nxt = r_count + {{AW{1'b0}}, 1'b1};
        end else if (w_rd_ok && !w_wr_ok) begin
            w_count_nxt = r_count - {{AW{1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else begin
            r_wptr  <= w_wptr_nxt;
            r_rptr  <= w_rptr_nxt;
            r_count <= w_count_nxt;
            r_empty <= (w_wptr_nxt == w_rptr_nxt);
            r_full  <= ptr_full(ptr_t'(w_wptr_nxt), ptr_t'(w_rptr_nxt), AW);
            r_ovf   <= r_ovf | (WE & r_full);
            r_unf   <= r_unf | (RE & r_empty);
        end
    end

    ram_dist_sdp #(
        .WIDTH (WIDTH),
        .AW    (AW)
    ) u_ram (
        .CLK (CLK),
        .WE  (w_wr_ok),
        .WA  (r_wptr[AW-1:0]),
        .D   (D),
        .RA  (r_rptr[AW-1:0]),
        .O   (O)
    );

    assign FULL  = r_full;
    assign EMPTY = r_empty;
    assign COUNT = r_count;
    assign OVF   = r_ovf;
    assign UNF   = r_unf;

`ifdef DIST_RAM_FIFO_THRESH_EN
    logic r_afull;
    logic r_aempty;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_afull  <= 1'b0;
            r_aempty <= 1'b1;
        end else begin
            r_afull  <= (w_count_nxt >= (AW+1)'(AF_LVL));
            r_aempty <= (w_count_nxt <= (AW+1)'(AE_LVL));
        end
    end

    assign AFULL  = r_afull;
    assign AEMPTY = r_aempty;
`endif

endmodule
